// File: rtl/blackjack_pkg.sv
// Shared types and constants for the blackjack input conditioner.
// Button indices double as the bit positions of the per-button press vector.
package blackjack_pkg;

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_LOAD     = 2'd1,
        ST_FIRE     = 2'd2,
        ST_SEEDED   = 2'd3
    } bj_state_t;

    localparam int unsigned BTN_HIT    = 0;
    localparam int unsigned BTN_STAND  = 1;
    localparam int unsigned BTN_DOUBLE = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned NUM_BTN    = 4;

    localparam logic [15:0] SEED_MIX   = 16'hBEEF;
    localparam logic [15:0] SEED_SUBST = 16'h0001;

    // An all-zero seed would stall an LFSR-style generator in the core.
    function automatic logic [15:0] mix_seed(input logic [15:0] cnt);
        logic [15:0] mixed;
        mixed = cnt ^ SEED_MIX;
        return (mixed == 16'h0000) ? SEED_SUBST : mixed;
    endfunction

endpackage

// File: rtl/blackjack_input_ctrl_if.sv
// Command/seed bundle between the input conditioner (master) and blackjack_core (slave).
interface blackjack_input_ctrl_if;

    logic        btn_hit;
    logic        btn_stand;
    logic        btn_double;
    logic        btn_start;
    logic        rng_load;
    logic [15:0] rng_seed;

    modport master (
        output btn_hit,
        output btn_stand,
        output btn_double,
        output btn_start,
        output rng_load,
        output rng_seed
    );

    modport slave (
        input btn_hit,
        input btn_stand,
        input btn_double,
        input btn_start,
        input rng_load,
        input rng_seed
    );

endinterface

// File: rtl/bj_debounce.sv
// One push-button channel: 2-flop synchroniser, persistence counter, debounced level
// and a single-cycle press flag on its 0->1 transition.
module bj_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          db;
    logic          db_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            db     <= 1'b0;
            db_q   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            db_q   <= db;
            // Any return to the accepted level restarts the persistence window.
            if (sync_2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync_2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = db & ~db_q;

endmodule

// File: rtl/blackjack_input_ctrl.sv
// Button conditioner and seed sequencer in front of blackjack_core.
// Define BJ_RESEED_EN to take a fresh seed on every start press instead of once per reset.
//
// state     | meaning
// UNSEEDED  | no seed issued since reset; start press captures a seed
// LOAD      | rng_load strobe is out; start pulse follows next
// FIRE      | btn_start strobe is out; presses are ignored
// SEEDED    | seed in place; presses forwarded as plain pulses
module blackjack_input_ctrl
    import blackjack_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  raw_hit,
    input  logic                  raw_stand,
    input  logic                  raw_double,
    input  logic                  raw_start,
    blackjack_input_ctrl_if.master cmd
);

`ifdef BJ_RESEED_EN
    localparam bit RESEED_EN = 1'b1;
`else
    localparam bit RESEED_EN = 1'b0;
`endif

    logic [NUM_BTN-1:0] raw_vec;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] grant;
    logic [15:0]        ent_cnt;
    bj_state_t          state;

    logic        btn_hit_q;
    logic        btn_stand_q;
    logic        btn_double_q;
    logic        btn_start_q;
    logic        rng_load_q;
    logic [15:0] rng_seed_q;

    assign raw_vec[BTN_HIT]    = raw_hit;
    assign raw_vec[BTN_STAND]  = raw_stand;
    assign raw_vec[BTN_DOUBLE] = raw_double;
    assign raw_vec[BTN_START]  = raw_start;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        bj_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_vec[i]),
            .press (press[i])
        );
    end

    // Simultaneous presses: one winner, the rest are lost rather than queued.
    always_comb begin
        grant = '0;
        if (press[BTN_START]) begin
            grant[BTN_START] = 1'b1;
        end else if (press[BTN_STAND]) begin
            grant[BTN_STAND] = 1'b1;
        end else if (press[BTN_DOUBLE]) begin
            grant[BTN_DOUBLE] = 1'b1;
        end else if (press[BTN_HIT]) begin
            grant[BTN_HIT] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_cnt <= 16'h0000;
        end else begin
            ent_cnt <= ent_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_UNSEEDED;
            btn_hit_q    <= 1'b0;
            btn_stand_q  <= 1'b0;
            btn_double_q <= 1'b0;
            btn_start_q  <= 1'b0;
            rng_load_q   <= 1'b0;
            rng_seed_q   <= 16'h0000;
        end else begin
            btn_hit_q    <= 1'b0;
            btn_stand_q  <= 1'b0;
            btn_double_q <= 1'b0;
            btn_start_q  <= 1'b0;
            rng_load_q   <= 1'b0;
            case (state)
                ST_UNSEEDED, ST_SEEDED: begin
                    if (grant[BTN_START]) begin
                        if (state == ST_UNSEEDED || RESEED_EN) begin
                            rng_seed_q <= mix_seed(ent_cnt);
                            rng_load_q <= 1'b1;
                            state      <= ST_LOAD;
                        end else begin
                            btn_start_q <= 1'b1;
                        end
                    end
                    btn_stand_q  <= grant[BTN_STAND];
                    btn_double_q <= grant[BTN_DOUBLE];
                    btn_hit_q    <= grant[BTN_HIT];
                end
                ST_LOAD: begin
                    btn_start_q <= 1'b1;
                    state       <= ST_FIRE;
                end
                ST_FIRE: begin
                    state <= ST_SEEDED;
                end
                default: begin
                    state <= ST_UNSEEDED;
                end
            endcase
        end
    end

    assign cmd.btn_hit    = btn_hit_q;
    assign cmd.btn_stand  = btn_stand_q;
    assign cmd.btn_double = btn_double_q;
    assign cmd.btn_start  = btn_start_q;
    assign cmd.rng_load   = rng_load_q;
    assign cmd.rng_seed   = rng_seed_q;

endmodule

// File: tb/tb_blackjack_input_ctrl.sv
// Self-checking bench for blackjack_input_ctrl with DEBOUNCE_CYCLES=4: directed
// scenarios with literal expectations plus randomized pin activity against a reference model.
module tb_blackjack_input_ctrl;

    localparam int DC = 4;

`ifdef BJ_RESEED_EN
    localparam bit RESEED = 1'b1;
`else
    localparam bit RESEED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic raw_hit = 1'b0;
    logic raw_stand = 1'b0;
    logic raw_double = 1'b0;
    logic raw_start = 1'b0;

    blackjack_input_ctrl_if cmd_if ();

    blackjack_input_ctrl #(
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_hit    (raw_hit),
        .raw_stand  (raw_stand),
        .raw_double (raw_double),
        .raw_start  (raw_start),
        .cmd        (cmd_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a level is accepted once the last DC synchronised samples
    // (pin samples delayed by two edges) all disagree with it; rises become presses
    // that act one edge later.
    bit          m_started = 1'b0;
    logic [DC+1:0] m_hist [4];
    bit [3:0]    m_db;
    bit [3:0]    m_pr;
    bit          m_seeded;
    int          m_phase;
    logic [15:0] m_cnt;
    logic [15:0] m_seed;
    logic [4:0]  m_exp;   // {hit, stand, double, start, load}

    always @(posedge clk) begin
        logic [3:0]    rawv;
        logic [DC-1:0] win;
        logic [15:0]   mixed;
        rawv = {raw_start, raw_double, raw_stand, raw_hit};
        if (!rst_n) begin
            m_started = 1'b1;
            for (int b = 0; b < 4; b++) m_hist[b] = '0;
            m_db = '0; m_pr = '0; m_seeded = 1'b0; m_phase = 0;
            m_cnt = 16'h0000; m_seed = 16'h0000; m_exp = '0;
        end else begin
            m_exp = '0;
            if (m_phase == 1) begin
                m_exp[1] = 1'b1;
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_phase = 0;
            end else if (m_pr[3]) begin
                if (!m_seeded || RESEED) begin
                    mixed = m_cnt ^ 16'hBEEF;
                    m_seed = (mixed == 16'h0000) ? 16'h0001 : mixed;
                    m_exp[0] = 1'b1;
                    m_phase = 1;
                    m_seeded = 1'b1;
                end else begin
                    m_exp[1] = 1'b1;
                end
            end else if (m_pr[1]) m_exp[3] = 1'b1;
            else if (m_pr[2]) m_exp[2] = 1'b1;
            else if (m_pr[0]) m_exp[4] = 1'b1;
            m_cnt = m_cnt + 16'd1;
            for (int b = 0; b < 4; b++) begin
                m_hist[b] = {m_hist[b][DC:0], rawv[b]};
                win = m_hist[b][DC+1:2];
                m_pr[b] = 1'b0;
                if ((m_db[b] && win == '0) || (!m_db[b] && win == '1)) begin
                    m_db[b] = ~m_db[b];
                    m_pr[b] = m_db[b];
                end
            end
        end
    end

    function automatic logic [4:0] dut_strobes();
        return {cmd_if.btn_hit, cmd_if.btn_stand, cmd_if.btn_double,
                cmd_if.btn_start, cmd_if.rng_load};
    endfunction

    always @(negedge clk) begin
        logic [4:0] act;
        if (m_started) begin
            act = dut_strobes();
            n_checks++;
            if (act !== m_exp || cmd_if.rng_seed !== m_seed) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t strobes(h,s,d,st,ld) got=%b want=%b seed got=%h want=%h",
                         $time, act, m_exp, cmd_if.rng_seed, m_seed);
            end
            n_checks++;
            if ($countones(act) > 1) begin
                n_fail++;
                $display("FAIL one_strobe t=%0t strobes got=%b want at most one high", $time, act);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        tick(n);
        rst_n = 1'b1;
    endtask

    task automatic raws_low();
        raw_hit = 1'b0; raw_stand = 1'b0; raw_double = 1'b0; raw_start = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog t=%0t bench did not finish within time limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        raws_low();
        rst_n = 1'b0;
        @(negedge clk);

        // 1: reset held with pins toggling
        for (int i = 0; i < 10; i++) begin
            {raw_hit, raw_stand, raw_double, raw_start} = 4'($urandom);
            tick(1);
            chk("rst_quiet", {11'h0, dut_strobes(), cmd_if.rng_seed}, 32'h0);
        end
        raws_low();
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_quiet", {11'h0, dut_strobes(), cmd_if.rng_seed}, 32'h0);
        tick(10);

        // 2: bouncing hit, then held
        for (int i = 0; i < 5; i++) begin
            raw_hit = 1'b1; tick(2);
            raw_hit = 1'b0; tick(2);
        end
        raw_hit = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("hit_early", cmd_if.btn_hit, 1'b0);
        end
        tick(1);
        chk("hit_latency", cmd_if.btn_hit, 1'b1);
        tick(1);
        chk("hit_width", cmd_if.btn_hit, 1'b0);
        tick(20);
        raw_hit = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            chk("hit_release", cmd_if.btn_hit, 1'b0);
        end

        // 3: first start seeds, second start does not (unless reseeding)
        do_reset(3);
        raw_start = 1'b1;
        tick(6);
        chk("load_early", cmd_if.rng_load, 1'b0);
        tick(1);
        chk("load_first", cmd_if.rng_load, 1'b1);
        chk("seed_first", cmd_if.rng_seed, 16'hBEE9);
        chk("start_not_yet", cmd_if.btn_start, 1'b0);
        tick(1);
        chk("start_after_load", cmd_if.btn_start, 1'b1);
        chk("load_one_cycle", cmd_if.rng_load, 1'b0);
        tick(10);
        raw_start = 1'b0;
        tick(20);
        raw_start = 1'b1;
        tick(7);
        if (RESEED) begin
            chk("reseed_load", cmd_if.rng_load, 1'b1);
        end else begin
            chk("second_start", cmd_if.btn_start, 1'b1);
            chk("second_noload", cmd_if.rng_load, 1'b0);
            chk("seed_hold", cmd_if.rng_seed, 16'hBEE9);
        end
        tick(10);
        raw_start = 1'b0;
        tick(20);

        // 4: start and hit together
        do_reset(3);
        raw_start = 1'b1;
        raw_hit = 1'b1;
        tick(7);
        chk("tie_load", cmd_if.rng_load, 1'b1);
        chk("tie_nohit", cmd_if.btn_hit, 1'b0);
        tick(1);
        chk("tie_start", cmd_if.btn_start, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("tie_hit_dropped", cmd_if.btn_hit, 1'b0);
        end
        raws_low();
        tick(20);

        // 5: capture at counter 16'hBEEF gives the substitute seed
        do_reset(3);
        tick(48873);
        raw_start = 1'b1;
        tick(7);
        chk("zero_seed_load", cmd_if.rng_load, 1'b1);
        chk("zero_seed_subst", cmd_if.rng_seed, 16'h0001);
        tick(5);
        raw_start = 1'b0;
        tick(20);

        // 6: stand held across reset
        raw_stand = 1'b1;
        tick(15);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("stand_early", cmd_if.btn_stand, 1'b0);
        end
        tick(1);
        chk("stand_after_rst", cmd_if.btn_stand, 1'b1);
        tick(1);
        chk("stand_width", cmd_if.btn_stand, 1'b0);
        raw_stand = 1'b0;
        tick(10);
        raw_start = 1'b1;
        tick(7);
        chk("unseeded_after_rst", cmd_if.rng_load, 1'b1);
        tick(5);
        raw_start = 1'b0;
        tick(20);

        // Randomized pin activity against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end
            {raw_hit, raw_stand, raw_double, raw_start} = 4'($urandom);
            hold = int'($urandom_range(1, 12));
            tick(hold);
        end
        raws_low();
        tick(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
